// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit with HI/LO registers
// Optional feature: define MDU_DIVZERO_HOLD_EN to leave HI/LO untouched on divide-by-zero.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
`ifdef MDU_DIVZERO_HOLD_EN
    logic        pend_hold;
`endif

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic        div_signed;
    logic        neg_a;
    logic        neg_b;
    logic        div_zero;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    // One 64-bit multiplier serves both flavours: signedness is just the extension.
    always_comb begin
        ext_a   = {(mdop == OP_MULT) ? {32{a[31]}} : 32'd0, a};
        ext_b   = {(mdop == OP_MULT) ? {32{b[31]}} : 32'd0, b};
        product = ext_a * ext_b;
    end

    // Signed division runs on magnitudes so that 0x80000000 / -1 cannot overflow.
    always_comb begin
        div_signed = (mdop == OP_DIV);
        neg_a      = div_signed & a[31];
        neg_b      = div_signed & b[31];
        div_zero   = (b == 32'd0);
        mag_a      = neg_a ? -a : a;
        mag_b      = neg_b ? -b : b;
        divisor    = div_zero ? 32'd1 : mag_b;
        uq         = mag_a / divisor;
        ur         = mag_a % divisor;
        div_quo    = (neg_a ^ neg_b) ? -uq : uq;
        div_rem    = neg_a ? -ur : ur;
        if (div_zero) begin
            div_quo = 32'hFFFF_FFFF;
            div_rem = a;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
`ifdef MDU_DIVZERO_HOLD_EN
            pend_hold <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (mdop)
                            OP_MULT, OP_MULTU: begin
                                pend_hi <= product[63:32];
                                pend_lo <= product[31:0];
                                cnt     <= MULT_LOAD;
                                state   <= MUL;
                                busy    <= 1'b1;
`ifdef MDU_DIVZERO_HOLD_EN
                                pend_hold <= 1'b0;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi <= div_rem;
                                pend_lo <= div_quo;
                                cnt     <= DIV_LOAD;
                                state   <= DIV;
                                busy    <= 1'b1;
`ifdef MDU_DIVZERO_HOLD_EN
                                pend_hold <= div_zero;
`endif
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL, DIV: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
`ifdef MDU_DIVZERO_HOLD_EN
                        if (!pend_hold) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
`else
                        hi <= pend_hi;
                        lo <= pend_lo;
`endif
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - vector table plus scoreboard bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mdop = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];

    muldiv_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .mdop    (mdop),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int n0);
        int   n;
        exp_t e;
        n = n0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check("busy_cycles", 32'(n), 32'(e.cycles));
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el, input int ec);
        sb.push_back('{eh, el, ec});
        @(negedge clk);
        start = 1'b1; mdop = op; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; mdop = 3'd0; a = $urandom; b = $urandom;
        wait_done(0);
    endtask

    initial begin
        bit saw_busy;

        vecs[0]  = '{3'd1, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{3'd4, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 10};
        vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[5]  = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[6]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
        vecs[7]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[8]  = '{3'd5, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h0000_0001, 0};
        vecs[9]  = '{3'd6, 32'hCAFE_F00D, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D, 0};
        vecs[10] = '{3'd7, 32'hDEAD_BEEF, 32'h1111_1111, 32'h1234_5678, 32'hCAFE_F00D, 0};
        vecs[11] = '{3'd0, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1234_5678, 32'hCAFE_F00D, 0};
`ifdef MDU_DIVZERO_HOLD_EN
        vecs[12] = '{3'd4, 32'h0000_0055, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D, 10};
`else
        vecs[12] = '{3'd4, 32'h0000_0055, 32'h0000_0000, 32'h0000_0055, 32'hFFFF_FFFF, 10};
`endif

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++)
            run_op(vecs[i].op, vecs[i].av, vecs[i].bv, vecs[i].hi, vecs[i].lo, vecs[i].cycles);

        // start during a divide must be ignored, including mthi and a mult restart
        sb.push_back('{32'd2, 32'd14, 10});
        @(negedge clk);
        start = 1'b1; mdop = 3'd4; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; mdop = 3'd5; a = 32'h1234_5678;
        @(negedge clk);
        mdop = 3'd1; a = 32'd3; b = 32'd5;
        @(negedge clk);
        start = 1'b0; mdop = 3'd0;
        wait_done(3);
        run_op(3'd5, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'd14, 0);

        // reset in the middle of a multiply aborts it for good
        @(negedge clk);
        start = 1'b1; mdop = 3'd1; a = 32'd5; b = 32'd6;
        @(negedge clk);
        start = 1'b0; mdop = 3'd0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        saw_busy = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("abort_no_busy", 32'(saw_busy), 32'd0);
        check("abort_hi_after", hi, 32'd0);
        check("abort_lo_after", lo, 32'd0);

        run_op(3'd2, 32'd2, 32'd3, 32'd0, 32'd6, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
